// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: command mode codes and controller states.
package usr_pkg;

    localparam logic [2:0] MODE_LOAD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_CLEAR = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/universal_shift_register_shift_step_unit.sv
// One combinational step of STEP bits: next register value and the bits pushed out.
module shift_step_unit
    import usr_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int STEP = 1
) (
    input  logic [SIZE-1:0] value_i,
    input  logic [2:0]      mode_i,
    input  logic [STEP-1:0] ser_in_i,
    output logic [SIZE-1:0] next_o,
    output logic [STEP-1:0] expelled_o
);

    always_comb begin
        next_o     = value_i;
        expelled_o = '0;
        case (mode_i)
            MODE_SHL: begin
                next_o     = {value_i[SIZE-STEP-1:0], ser_in_i};
                expelled_o = value_i[SIZE-1 -: STEP];
            end
            MODE_SHR: begin
                next_o     = {ser_in_i, value_i[SIZE-1:STEP]};
                expelled_o = value_i[STEP-1:0];
            end
            // rotates feed the expelled bits back in at the opposite end
            MODE_ROL: begin
                next_o     = {value_i[SIZE-STEP-1:0], value_i[SIZE-1 -: STEP]};
                expelled_o = value_i[SIZE-1 -: STEP];
            end
            MODE_ROR: begin
                next_o     = {value_i[STEP-1:0], value_i[SIZE-1:STEP]};
                expelled_o = value_i[STEP-1:0];
            end
            default: begin
                next_o     = value_i;
                expelled_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Multi-mode shift register with command handshake and step-gated sequencing.
// Rotate commands (ROL/ROR) exist only when USR_ROTATE_EN is defined; otherwise they are illegal.
//
//   state    | meaning
//   ST_IDLE  | cmd_ready high; LOAD/CLEAR/zero-count/illegal complete in one edge
//   ST_SHIFT | busy; one step per edge with shift_en_i high until remaining reaches 1
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_mode_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic [SIZE-1:0]  load_data_i,
    input  logic [STEP-1:0]  ser_in_i,
    input  logic             shift_en_i,
    output logic [SIZE-1:0]  out_o,
    output logic [STEP-1:0]  ser_out_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state_q;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] remaining_q;
    logic [SIZE-1:0]  out_q;
    logic [STEP-1:0]  ser_out_q;
    logic             done_q;
    logic [SIZE-1:0]  step_value_d;
    logic [STEP-1:0]  step_expelled_d;
    logic             mode_is_shift;

    shift_step_unit #(
        .SIZE (SIZE),
        .STEP (STEP)
    ) u_step (
        .value_i    (out_q),
        .mode_i     (mode_q),
        .ser_in_i   (ser_in_i),
        .next_o     (step_value_d),
        .expelled_o (step_expelled_d)
    );

    always_comb begin
        mode_is_shift = (cmd_mode_i == MODE_SHL) || (cmd_mode_i == MODE_SHR);
`ifdef USR_ROTATE_EN
        mode_is_shift = mode_is_shift || (cmd_mode_i == MODE_ROL) || (cmd_mode_i == MODE_ROR);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_LOAD;
            remaining_q <= '0;
            out_q       <= '0;
            ser_out_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        if (mode_is_shift && (cmd_count_i != '0)) begin
                            mode_q      <= cmd_mode_i;
                            remaining_q <= cmd_count_i;
                            state_q     <= ST_SHIFT;
                        end else begin
                            done_q <= 1'b1;
                            if (cmd_mode_i == MODE_LOAD) begin
                                out_q <= load_data_i;
                            end else if (cmd_mode_i == MODE_CLEAR) begin
                                out_q <= '0;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    if (shift_en_i) begin
                        out_q       <= step_value_d;
                        ser_out_q   <= step_expelled_d;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_SHIFT);
    assign out_o       = out_q;
    assign ser_out_o   = ser_out_q;
    assign done_o      = done_q;

endmodule
